global_mean_segment: RTL and testbench
======================================

GLOBAL_MEAN_SEGMENT -- requirements
Module: global_mean_segment

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width.
REQ-002 SHALL have parameter H_DISP, default 12'd640, image width.
REQ-003 SHALL have parameter V_DISP, default 12'd480, image height.
REQ-004 SHALL have parameter INIT_THRESH, default 100, threshold used until the first auto mean exists.
REQ-005 SHALL derive CNT_W = ceil(log2(H_DISP*V_DISP+1)) and SUM_W = DATA_W+CNT_W.
REQ-006 SHALL have ports:
  - clk  in  1  sole clock.
  - rst_n  in  1  asynchronous active-low reset.
  - Y_hsync  in  1  input line sync.
  - Y_vsync  in  1  input frame sync; rising edge marks frame start.
  - Y_data  in  DATA_W  input luma.
  - Y_de  in  1  input data enable.
  - mode  in  2  0 binary, 1 inverted binary, 2 to-zero, 3 truncate.
  - thresh_sel  in  1  0 manual, 1 auto mean.
  - manual_thresh  in  DATA_W  manual threshold.
  - thresh_offset  in  DATA_W+1  signed offset added to the auto mean.
  - segment_hsync  out  1  delayed Y_hsync.
  - segment_vsync  out  1  delayed Y_vsync.
  - segment_data  out  DATA_W  segmented pixel.
  - segment_de  out  1  delayed Y_de.
  - cur_thresh  out  DATA_W  effective threshold of the current frame.
  - thresh_valid  out  1  high once at least one auto mean has been computed.

Function
REQ-007 SHALL delay Y_hsync, Y_vsync and Y_de by exactly 1 clk onto the segment_* sync outputs.
REQ-008 SHALL update segment_data 1 clk after a cycle with Y_de=1, and SHALL hold segment_data while Y_de=0.
REQ-009 SHALL compute segment_data from T=cur_thresh and pixel p, comparison strictly p>T:
  - mode 0: p>T gives all-ones, else 0.
  - mode 1: p>T gives 0, else all-ones.
  - mode 2: p>T gives p, else 0.
  - mode 3: p>T gives T, else p.
REQ-010 SHALL sample mode, thresh_sel, manual_thresh and thresh_offset only at a Y_vsync rising edge (frame latch), and SHALL hold the latched values for the whole frame.
REQ-011 SHALL set cur_thresh at each frame latch:
  - thresh_sel=0: manual_thresh.
  - thresh_sel=1: auto mean plus thresh_offset (signed), saturated to [0, 2^DATA_W-1].
REQ-012 SHALL, while Y_de=1, accumulate pixel sum (SUM_W bits) and pixel count (CNT_W bits); once count reaches 2^CNT_W-1, both SHALL stop accumulating.
REQ-013 SHALL, at a Y_vsync rising edge, copy sum and count into the divider and clear both accumulators in the same cycle, so the new frame's first pixel is counted.
REQ-014 SHALL implement a divider FSM with states IDLE, DIV, DONE.
  - IDLE goes to DIV on a vsync edge with a non-zero latched count.
  - DIV runs restoring division, one quotient bit per clk, for SUM_W clks.
  - DIV then goes to DONE.
  - DONE writes the auto mean = floor(sum/count), truncated to DATA_W, sets thresh_valid=1, and returns to IDLE next clk.
REQ-015 SHALL, on a vsync edge with latched count=0, stay in IDLE and leave the auto mean unchanged.
REQ-016 SHALL, on a vsync edge while in DIV or DONE, abort the division and restart it in DIV with the newly latched sum and count.
REQ-017 SHALL use, at a frame latch, the auto mean value present in that cycle; because the mean updates SUM_W+1 clks after the edge, it applies from the frame after next.
  - Until the first DONE, the auto mean SHALL equal INIT_THRESH.

Reset
REQ-018 SHALL, on rst_n low asynchronously, set:
  - segment_data=0, segment_de=0, segment_hsync=0, segment_vsync=0.
  - cur_thresh=INIT_THRESH, auto mean=INIT_THRESH, thresh_valid=0.
  - accumulators=0, FSM=IDLE, latched controls to mode 0 / thresh_sel 0 / manual_thresh INIT_THRESH / offset 0.
REQ-019 SHALL, on reset asserted mid-division, discard the division, and SHALL produce no DONE after release until a new vsync edge.

Verification
REQ-020 SHALL cover reset: assert rst_n=0 mid-frame -> all outputs 0, cur_thresh=100, thresh_valid=0 with no clk edge needed.
REQ-021 SHALL cover manual mode 0 at threshold 100: Y_data 101 then 100 with Y_de=1 -> segment_data 0xFF then 0x00, each 1 clk later; syncs delayed 1 clk.
REQ-022 SHALL cover auto mode (H_DISP=8, V_DISP=4): frame of 32 pixels all value 60, then vsync edge -> thresh_valid=1 and mean=60 SUM_W+1 clks later; two frames on, pixel 61 gives 0xFF and 60 gives 0x00.
REQ-023 SHALL cover offset saturation: mean 250 with offset +20 -> cur_thresh=255, every pixel gives 0x00 in mode 0; mean 10 with offset -20 -> cur_thresh=0.
REQ-024 SHALL cover modes at T=100: pixel 150/50 -> mode 1: 0x00/0xFF; mode 2: 150/0; mode 3: 100/50.
REQ-025 SHALL cover boundaries:
  - a frame with no Y_de -> auto mean unchanged.
  - a vsync edge 5 clks into DIV -> division restarts, and the result reflects the second frame only.

Source files
------------

// File: rtl/global_mean_segment.sv
// global_mean_segment
// Thresholds a luma stream against a per-frame threshold. The threshold is
// either a manual value or the mean luma of an earlier frame plus a signed
// offset, saturated to the pixel range. The frame mean is computed by a
// serial restoring divider that runs after each frame-start edge.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   Y_hsync/Y_vsync    input syncs (Y_vsync rising edge = frame start)
//   Y_data, Y_de       input luma and data enable
//   mode               0 binary, 1 inverted binary, 2 to-zero, 3 truncate
//   thresh_sel         0 manual threshold, 1 auto mean + offset
//   manual_thresh      manual threshold
//   thresh_offset      signed offset added to the auto mean
//   segment_*          syncs delayed one clock, segmented pixel
//   cur_thresh         threshold in effect for the current frame
//   thresh_valid       high once at least one auto mean has been produced
module global_mean_segment #(
  parameter int          DATA_W      = 8,
  parameter logic [11:0] H_DISP      = 12'd640,
  parameter logic [11:0] V_DISP      = 12'd480,
  parameter int          INIT_THRESH = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Y_hsync,
  input  logic              Y_vsync,
  input  logic [DATA_W-1:0] Y_data,
  input  logic              Y_de,
  input  logic [1:0]        mode,
  input  logic              thresh_sel,
  input  logic [DATA_W-1:0] manual_thresh,
  input  logic [DATA_W:0]   thresh_offset,
  output logic              segment_hsync,
  output logic              segment_vsync,
  output logic [DATA_W-1:0] segment_data,
  output logic              segment_de,
  output logic [DATA_W-1:0] cur_thresh,
  output logic              thresh_valid
);

  // Widen before multiplying so the pixel count cannot wrap in 12 bits.
  localparam int unsigned NPIX   = 32'(H_DISP) * 32'(V_DISP);
  localparam int          CNT_W  = $clog2(NPIX + 32'd1);
  localparam int          SUM_W  = DATA_W + CNT_W;
  localparam int          STEP_W = $clog2(SUM_W + 1);
  localparam logic [DATA_W-1:0] INIT_T  = DATA_W'(INIT_THRESH);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   auto_mean_q;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    quot_q;     // dividend shifts out, quotient shifts in
  logic [CNT_W-1:0]    div_q;
  logic [CNT_W-1:0]    rem_q;
  logic [STEP_W-1:0]   step_q;

  logic                vs_rise_s;
  logic [DATA_W-1:0]   seg_s;
  logic [DATA_W-1:0]   thr_new_s;
  logic signed [DATA_W+1:0] adj_s;
  logic [CNT_W:0]      rem_sh_s, rem_nx_s;
  logic                ge_s;

  // Frame start: segment_vsync is Y_vsync from the previous clock.
  assign vs_rise_s = Y_vsync & ~segment_vsync;

  // Segmentation of the incoming pixel against the current threshold.
  always_comb begin
    seg_s = '0;
    case (mode_q)
      2'd0:    seg_s = (Y_data > cur_thresh) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      2'd1:    seg_s = (Y_data > cur_thresh) ? {DATA_W{1'b0}} : {DATA_W{1'b1}};
      2'd2:    seg_s = (Y_data > cur_thresh) ? Y_data : {DATA_W{1'b0}};
      2'd3:    seg_s = (Y_data > cur_thresh) ? cur_thresh : Y_data;
      default: seg_s = '0;
    endcase
  end

  // Threshold for the next frame; auto path is mean + signed offset, clamped.
  always_comb begin
    adj_s = $signed({2'b00, auto_mean_q}) + $signed({thresh_offset[DATA_W], thresh_offset});
    if (!thresh_sel) begin
      thr_new_s = manual_thresh;
    end else if (adj_s[DATA_W+1]) begin
      thr_new_s = '0;
    end else if (adj_s[DATA_W]) begin
      thr_new_s = {DATA_W{1'b1}};
    end else begin
      thr_new_s = adj_s[DATA_W-1:0];
    end
  end

  // Accumulators restart at frame start, including a pixel arriving that cycle.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (vs_rise_s) begin
      sum_d = Y_de ? SUM_W'(Y_data) : '0;
      cnt_d = Y_de ? CNT_W'(1) : '0;
    end else if (Y_de && (cnt_q != CNT_MAX)) begin
      sum_d = sum_q + SUM_W'(Y_data);
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      sum_d = sum_q;
      cnt_d = cnt_q;
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract if possible.
  always_comb begin
    rem_sh_s = {rem_q, quot_q[SUM_W-1]};
    ge_s     = (rem_sh_s >= {1'b0, div_q});
    if (ge_s) begin
      rem_nx_s = rem_sh_s - {1'b0, div_q};
    end else begin
      rem_nx_s = rem_sh_s;
    end
  end

  // Stream path: delayed syncs, held pixel output, accumulators, frame latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment_hsync <= 1'b0;
      segment_vsync <= 1'b0;
      segment_de    <= 1'b0;
      segment_data  <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      mode_q        <= 2'd0;
      cur_thresh    <= INIT_T;
    end else begin
      segment_hsync <= Y_hsync;
      segment_vsync <= Y_vsync;
      segment_de    <= Y_de;
      if (Y_de) begin
        segment_data <= seg_s;
      end
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      if (vs_rise_s) begin
        mode_q     <= mode;
        cur_thresh <= thr_new_s;
      end
    end
  end

  // Mean divider FSM; a new frame edge always restarts it with fresh totals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      quot_q       <= '0;
      div_q        <= '0;
      rem_q        <= '0;
      step_q       <= '0;
      auto_mean_q  <= INIT_T;
      thresh_valid <= 1'b0;
    end else if (vs_rise_s) begin
      // An empty frame gives no mean; any division in flight is dropped.
      if (cnt_q != '0) begin
        state_q <= DIV;
        quot_q  <= sum_q;
        div_q   <= cnt_q;
        rem_q   <= '0;
        step_q  <= '0;
      end else begin
        state_q <= IDLE;
      end
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        DIV: begin
          rem_q  <= rem_nx_s[CNT_W-1:0];
          quot_q <= {quot_q[SUM_W-2:0], ge_s};
          step_q <= step_q + STEP_W'(1);
          if (step_q == LAST_STEP) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          auto_mean_q  <= quot_q[DATA_W-1:0];
          thresh_valid <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_mean_segment.sv
module tb_global_mean_segment;

  localparam int SUM_W = 14; // 8 + ceil(log2(8*4+1))

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Y_hsync, Y_vsync, Y_de;
  logic [7:0] Y_data;
  logic [1:0] mode;
  logic       thresh_sel;
  logic [7:0] manual_thresh;
  logic [8:0] thresh_offset;
  logic       segment_hsync, segment_vsync, segment_de, thresh_valid;
  logic [7:0] segment_data, cur_thresh;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_T, m_mode, m_mean, m_valid, m_sum, m_cnt, m_pend, m_cd;
  logic       m_pvs;
  logic [7:0] m_seg;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  global_mean_segment #(
    .DATA_W(8), .H_DISP(12'd8), .V_DISP(12'd4), .INIT_THRESH(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Y_hsync(Y_hsync), .Y_vsync(Y_vsync), .Y_data(Y_data), .Y_de(Y_de),
    .mode(mode), .thresh_sel(thresh_sel), .manual_thresh(manual_thresh),
    .thresh_offset(thresh_offset),
    .segment_hsync(segment_hsync), .segment_vsync(segment_vsync),
    .segment_data(segment_data), .segment_de(segment_de),
    .cur_thresh(cur_thresh), .thresh_valid(thresh_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  function automatic int f_pix(int p, int t, int md);
    bit gt = (p > t);
    case (md)
      0:       return gt ? 255 : 0;
      1:       return gt ? 0 : 255;
      2:       return gt ? p : 0;
      default: return gt ? t : p;
    endcase
  endfunction

  function automatic int f_sat(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic m_reset();
    m_T = 100; m_mode = 0; m_mean = 100; m_valid = 0;
    m_sum = 0; m_cnt = 0; m_pend = 0; m_cd = 0;
    m_pvs = 1'b0; m_seg = 8'd0;
    sb.delete();
  endtask

  task automatic chk_reset();
    chk("rst_data", 32'(segment_data), 32'd0);
    chk("rst_de", 32'(segment_de), 32'd0);
    chk("rst_hs", 32'(segment_hsync), 32'd0);
    chk("rst_vs", 32'(segment_vsync), 32'd0);
    chk("rst_thresh", 32'(cur_thresh), 32'd100);
    chk("rst_valid", 32'(thresh_valid), 32'd0);
  endtask

  // One clock of stimulus; the model predicts the outputs after the edge.
  task automatic cyc(input logic hs, input logic vs, input logic de, input logic [7:0] d);
    int off;
    Y_hsync = hs; Y_vsync = vs; Y_de = de; Y_data = d;
    if (de) sb.push_back(8'(f_pix(int'(d), m_T, m_mode)));
    off = thresh_offset[8] ? int'(thresh_offset) - 512 : int'(thresh_offset);
    if (vs && !m_pvs) begin
      m_T    = thresh_sel ? f_sat(m_mean + off) : int'(manual_thresh);
      m_mode = int'(mode);
      if (m_cnt > 0) begin
        m_pend = (m_sum / m_cnt) % 256;
        m_cd   = SUM_W + 1;
      end else begin
        m_cd = 0;
      end
      m_sum = de ? int'(d) : 0;
      m_cnt = de ? 1 : 0;
    end else begin
      if (de && m_cnt < 63) begin
        m_sum += int'(d);
        m_cnt++;
      end
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_mean  = m_pend;
          m_valid = 1;
        end
      end
    end
    m_pvs = vs;
    @(posedge clk); #1;
    if (de) m_seg = sb.pop_front();
    chk("hsync", 32'(segment_hsync), 32'(hs));
    chk("vsync", 32'(segment_vsync), 32'(vs));
    chk("de", 32'(segment_de), 32'(de));
    chk("data", 32'(segment_data), 32'(m_seg));
    chk("cur_thresh", 32'(cur_thresh), 32'(m_T));
    chk("valid", 32'(thresh_valid), 32'(m_valid));
  endtask

  task automatic vs_pulse();
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic pix(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, v);
  endtask

  initial begin
    rst_n = 1'b0;
    Y_hsync = 1'b0; Y_vsync = 1'b0; Y_de = 1'b0; Y_data = 8'd0;
    mode = 2'd0; thresh_sel = 1'b0; manual_thresh = 8'd100; thresh_offset = 9'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rst_n = 1'b1;

    // manual binary at the reset threshold of 100
    cyc(1'b1, 1'b0, 1'b1, 8'd101);
    chk("man_101", 32'(segment_data), 32'd255);
    cyc(1'b1, 1'b0, 1'b1, 8'd100);
    chk("man_100", 32'(segment_data), 32'd0);
    idle(2);

    // remaining modes at T=100
    for (int m = 1; m < 4; m++) begin
      mode = 2'(m);
      vs_pulse();
      pix(1, 8'd150);
      pix(1, 8'd50);
      idle(1);
    end

    // over-long frame: accumulation stops at the count ceiling
    mode = 2'd0;
    vs_pulse();
    for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0, 1'b1, 8'(i * 3 + 1));
    vs_pulse();
    idle(20);

    // auto mean of a flat frame of 60
    thresh_sel = 1'b1; thresh_offset = 9'd0;
    vs_pulse();
    pix(32, 8'd60);
    vs_pulse();
    idle(20);
    vs_pulse();
    chk("auto_T", 32'(cur_thresh), 32'd60);
    chk("auto_valid", 32'(thresh_valid), 32'd1);
    pix(1, 8'd61);
    pix(1, 8'd60);

    // offset saturation high: mean 250 + 20
    vs_pulse();
    pix(8, 8'd250);
    vs_pulse();
    idle(20);
    thresh_offset = 9'd20;
    vs_pulse();
    chk("sat_hi", 32'(cur_thresh), 32'd255);
    pix(1, 8'd255);
    pix(1, 8'd0);
    pix(1, 8'd200);

    // offset saturation low: mean 10 - 20
    vs_pulse();
    pix(8, 8'd10);
    vs_pulse();
    idle(20);
    thresh_offset = 9'h1EC;
    vs_pulse();
    chk("sat_lo", 32'(cur_thresh), 32'd0);
    pix(1, 8'd0);
    pix(1, 8'd1);

    // empty frame leaves the mean alone
    thresh_offset = 9'd0;
    vs_pulse();
    pix(4, 8'd77);
    vs_pulse();
    idle(20);
    vs_pulse();
    idle(20);
    vs_pulse();
    chk("empty_keep", 32'(cur_thresh), 32'd77);

    // frame edge 5 clocks into the division restarts it
    pix(8, 8'd40);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    pix(4, 8'd20);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    idle(20);
    vs_pulse();
    chk("restart_T", 32'(cur_thresh), 32'd20);
    pix(1, 8'd21);
    pix(1, 8'd20);

    // asynchronous reset mid-frame and mid-division
    vs_pulse();
    pix(4, 8'd90);
    cyc(1'b0, 1'b1, 1'b0, 8'd0);
    idle(3);
    Y_hsync = 1'b1; Y_de = 1'b1; Y_data = 8'd200; Y_vsync = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset();
    m_reset();
    Y_hsync = 1'b0; Y_de = 1'b0; Y_data = 8'd0;
    thresh_sel = 1'b0; manual_thresh = 8'd100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
